// File: rtl/ncpu32k_pipe_slice.sv
// Two-entry registered valid/ready skid slice between CPU pipeline stages.
// Optional synchronous flush port when NCPU_PIPE_SLICE_FLUSH_EN is defined.
module ncpu32k_pipe_slice #(
    parameter int DW = 32,
    parameter logic [DW-1:0] RST_VECTOR = {DW{1'b0}}
) (
    input  logic          CLK,
    input  logic          RST_n,
`ifdef NCPU_PIPE_SLICE_FLUSH_EN
    input  logic          i_flush,
`endif
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_TWO   = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic          valid_q, ready_q;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          main_ld, skid_ld;
    logic          in_fire, out_fire;

    assign in_fire  = i_valid & ready_q;
    assign out_fire = valid_q & i_ready;

    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        main_d  = i_data;
        skid_d  = i_data;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    main_ld = 1'b1;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    skid_ld = 1'b1;
                    state_d = S_TWO;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_fire) begin
                    main_ld = 1'b1;
                    main_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
`ifdef NCPU_PIPE_SLICE_FLUSH_EN
        // Flush drops any incoming beat but leaves the data registers intact
        if (i_flush) begin
            main_ld = 1'b0;
            skid_ld = 1'b0;
            state_d = S_EMPTY;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != S_EMPTY);
            ready_q <= (state_d != S_TWO);
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            main_q <= RST_VECTOR;
            skid_q <= RST_VECTOR;
        end else begin
            if (main_ld) main_q <= main_d;
            if (skid_ld) skid_q <= skid_d;
        end
    end

    assign o_valid = valid_q;
    assign o_ready = ready_q;
    assign o_data  = main_q;

endmodule

// File: tb/tb_ncpu32k_pipe_slice.sv
// Randomized and directed bench for ncpu32k_pipe_slice.
// Reference model: a queue of beats held by the slice (depth <= 2).
module tb_ncpu32k_pipe_slice;

    localparam int DW = 32;
    localparam logic [DW-1:0] RV = 32'hA5A5_0F0F;

    logic          CLK;
    logic          RST_n;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
`ifdef NCPU_PIPE_SLICE_FLUSH_EN
    logic          i_flush;
`endif

    ncpu32k_pipe_slice #(.DW(DW), .RST_VECTOR(RV)) dut (
        .CLK     (CLK),
        .RST_n   (RST_n),
`ifdef NCPU_PIPE_SLICE_FLUSH_EN
        .i_flush (i_flush),
`endif
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] mq[$];
    bit rst_fresh;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("o_valid", 32'(o_valid), 32'(mq.size() > 0));
        chk("o_ready", 32'(o_ready), 32'(mq.size() < 2));
        if (mq.size() > 0)
            chk("o_data", o_data, mq[0]);
        else if (rst_fresh)
            chk("o_data_rst", o_data, RV);
    endtask

    // One clock: model advances on the same handshake rules, then compare
    task automatic cyc();
        bit in_f, out_f, fl;
        logic [DW-1:0] d;
        in_f  = i_valid && (mq.size() < 2);
        out_f = i_ready && (mq.size() > 0);
        d     = i_data;
        fl    = 1'b0;
`ifdef NCPU_PIPE_SLICE_FLUSH_EN
        fl    = i_flush;
`endif
        @(posedge CLK);
        if (out_f) void'(mq.pop_front());
        if (fl) mq.delete();
        else if (in_f) begin
            mq.push_back(d);
            rst_fresh = 1'b0;
        end
        #1;
        cmp_model();
    endtask

    initial begin
        RST_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
`ifdef NCPU_PIPE_SLICE_FLUSH_EN
        i_flush = 1'b0;
`endif
        rst_fresh = 1'b1;
        #12;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_data", o_data, RV);
        RST_n = 1'b1;
        cyc();

        // Streaming
        i_valid = 1'b1;
        i_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            i_data = 32'(k);
            cyc();
            chk("strm_data", o_data, 32'(k));
            chk("strm_ready", 32'(o_ready), 32'd1);
        end
        i_valid = 1'b0;
        cyc();

        // Backpressure
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data = 32'hA; cyc();
        i_data = 32'hB; cyc();
        chk("bp_ready0", 32'(o_ready), 32'd0);
        i_data = 32'hC; cyc();
        chk("bp_hold", o_data, 32'hA);
        i_ready = 1'b1;
        cyc();
        chk("bp_out_b", o_data, 32'hB);
        cyc();
        chk("bp_out_c", o_data, 32'hC);
        i_valid = 1'b0;
        cyc();
        chk("bp_empty", 32'(o_valid), 32'd0);

        // Stall hold
        i_valid = 1'b1;
        i_ready = 1'b0;
        i_data  = 32'h55;
        cyc();
        i_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("stall_data", o_data, 32'h55);
            chk("stall_valid", 32'(o_valid), 32'd1);
        end
        i_ready = 1'b1;
        cyc();
        chk("stall_drain", 32'(o_valid), 32'd0);

        // Random traffic
        for (int k = 0; k < 10000; k++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_data  = $urandom;
`ifdef NCPU_PIPE_SLICE_FLUSH_EN
            i_flush = ($urandom_range(0, 31) == 0);
`endif
            cyc();
        end
`ifdef NCPU_PIPE_SLICE_FLUSH_EN
        i_flush = 1'b0;
`endif
        i_valid = 1'b0;
        i_ready = 1'b1;
        cyc();
        cyc();

`ifdef NCPU_PIPE_SLICE_FLUSH_EN
        // Flush from TWO with a concurrent upstream beat
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data = 32'h1; cyc();
        i_data = 32'h2; cyc();
        i_data = 32'h3;
        i_flush = 1'b1;
        cyc();
        chk("fl_valid", 32'(o_valid), 32'd0);
        chk("fl_ready", 32'(o_ready), 32'd1);
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("fl_nodata", 32'(o_valid), 32'd0);
        end
`endif

        // Asynchronous reset while holding two beats
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data = 32'h1111; cyc();
        i_data = 32'h2222; cyc();
        chk("pre_rst_ready", 32'(o_ready), 32'd0);
        i_valid = 1'b0;
        #2;
        RST_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_ready", 32'(o_ready), 32'd1);
        chk("arst_data", o_data, RV);
        mq.delete();
        rst_fresh = 1'b1;
        @(posedge CLK);
        #2;
        RST_n = 1'b1;
        cyc();
        chk("post_rst_ready", 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_data = 32'h77;
        cyc();
        chk("post_rst_data", o_data, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
